stream_arbiter: RTL and testbench
=================================

STREAM_ARBITER -- requirements
Module: stream_arbiter

Interface
REQ-001 SHALL have parameter VID_ID, default 8'hE0, stream_id byte emitted for video packets.
REQ-002 SHALL have parameter AUD_ID, default 8'hC0, stream_id byte emitted for audio packets.
REQ-003 SHALL have parameter MAX_LEN, default 16'd2048, upper clamp on payload length.
REQ-004 SHALL have ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clk_en  in  1  advance enable; all registers hold when low.
- vid_req  in  1  video packet pending.
- vid_len  in  16  video payload length, valid while vid_req.
- vid_in  in  8  video byte, show-ahead, valid when ~vid_empty.
- vid_empty  in  1  video FIFO empty.
- vid_rd  out  1  video FIFO pop, combinational.
- vid_ack  out  1  one-cycle pulse: vid_req/vid_len accepted.
- vid_gnt  out  1  video owns output, level.
- aud_req, aud_len, aud_in, aud_empty, aud_rd, aud_ack, aud_gnt: same widths and meanings for audio.
- out_full  in  1  downstream cannot accept a byte.
- mpeg_out  out  8  registered output byte.
- mpeg_wr  out  1  registered write strobe for mpeg_out.
- busy  out  1  high in any state other than IDLE.

Function
REQ-005 SHALL implement an FSM with states IDLE, HDR, PAYLOAD; transitions are taken only on cycles with clk_en=1.
REQ-006 A transfer slot SHALL be a cycle with clk_en=1 and out_full=0.
REQ-007 IDLE: if only one req is high, grant it; if both are high, grant the requester not granted last; after reset, video wins the first tie.
REQ-008 On grant: latch len (clamped to MAX_LEN if larger), load the byte index to 0, pulse the matching *_ack for that one cycle, assert *_gnt, go to HDR.
REQ-009 *_gnt SHALL stay high from the cycle after the grant until the FSM re-enters IDLE.
REQ-010 Requester SHALL drop req or present a new len by the cycle after *_ack; the arbiter SHALL not sample req again until IDLE.
REQ-011 HDR SHALL emit 6 bytes, one per transfer slot: 8'h00, 8'h00, 8'h01, stream_id, len[15:8], len[7:0], where len is the clamped value.
REQ-012 After the 6th HDR byte: go to IDLE if len==0, else go to PAYLOAD with the payload counter set to len.
REQ-013 PAYLOAD: a byte transfers when the slot is valid and the granted FIFO is non-empty; in that cycle *_rd=1 combinationally, and the next edge sets mpeg_out to the FIFO byte and mpeg_wr to 1.
REQ-014 Each payload transfer SHALL decrement the 16-bit counter; the transfer with counter==1 returns the FSM to IDLE.
REQ-015 On any clk_en=1 cycle without a transfer, mpeg_wr SHALL be 0 at the next edge; with clk_en=0, mpeg_out and mpeg_wr hold, and downstream samples mpeg_wr only on clk_en cycles.
REQ-016 out_full=1 or granted FIFO empty SHALL stall with no state change, no index or counter change, and *_rd=0.
REQ-017 The non-granted FIFO's *_rd SHALL be 0 at all times.
REQ-018 Header and payload bytes SHALL be contiguous with no idle slot inserted, except stalls.
REQ-019 Re-entering IDLE with a req pending SHALL grant in that IDLE cycle, giving exactly one non-write slot between packets.
REQ-020 Counters SHALL not wrap: len is clamped before load, and the counter is never decremented at 0.

Reset
REQ-021 rst=1 SHALL immediately force: state IDLE, mpeg_out 8'h00, mpeg_wr 0, all *_ack/*_gnt 0, busy 0, counters 0, last-granted = audio (video wins the first tie).
REQ-022 Reset mid-packet SHALL abandon the packet without further writes; FIFO contents are untouched.
REQ-023 All *_rd SHALL be 0 while rst=1.

Verification
REQ-024 vid_req, vid_len=3, FIFO holds AA BB CC, out_full=0 -> mpeg_out 00 00 01 E0 00 03 AA BB CC on 9 consecutive mpeg_wr cycles; vid_ack pulses once; busy low after.
REQ-025 vid_req and aud_req both high, len=1 each -> video packet first, then audio (C0), then video again if still requesting; one idle slot between packets.
REQ-026 aud_len=16'hFFFF -> header length bytes 08 00; exactly 2048 payload bytes popped.
REQ-027 len=0 -> only 6 header bytes, no *_rd; out_full toggling every other cycle mid-payload -> no byte lost or duplicated.
REQ-028 vid_empty high for 5 cycles mid-payload, then rst pulsed during payload byte 2 of 4 -> mpeg_wr 0 throughout the empty gap and after reset; vid_rd 0; state IDLE.
REQ-029 clk_en=0 for 3 cycles mid-header -> all outputs frozen; sequence resumes unchanged.

Source files
------------

// File: rtl/stream_arbiter.sv
// Two-source packet arbiter: wraps a video or audio payload in a 6-byte header onto one registered byte stream.
// One-cycle latency from FIFO pop to mpeg_wr; out_full, an empty granted FIFO or clk_en=0 stall in place.
module stream_arbiter #(
    parameter logic [7:0]  VID_ID  = 8'hE0,
    parameter logic [7:0]  AUD_ID  = 8'hC0,
    parameter logic [15:0] MAX_LEN = 16'd2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        vid_req,
    input  logic [15:0] vid_len,
    input  logic [7:0]  vid_in,
    input  logic        vid_empty,
    output logic        vid_rd,
    output logic        vid_ack,
    output logic        vid_gnt,
    input  logic        aud_req,
    input  logic [15:0] aud_len,
    input  logic [7:0]  aud_in,
    input  logic        aud_empty,
    output logic        aud_rd,
    output logic        aud_ack,
    output logic        aud_gnt,
    input  logic        out_full,
    output logic [7:0]  mpeg_out,
    output logic        mpeg_wr,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

    state_t      state;
    logic        sel_aud;
    logic        last_aud;
    logic [15:0] len_q;
    logic [15:0] cnt;
    logic [2:0]  idx;

    logic        pick_aud;
    logic [15:0] req_len;
    logic [15:0] req_len_clamped;
    logic        src_empty;
    logic [7:0]  src_byte;
    logic        xfer;
    logic [7:0]  hdr_byte;

    // Round-robin on ties: the side not granted last wins.
    assign pick_aud        = aud_req & (~vid_req | ~last_aud);
    assign req_len         = pick_aud ? aud_len : vid_len;
    assign req_len_clamped = (req_len > MAX_LEN) ? MAX_LEN : req_len;

    assign src_empty = sel_aud ? aud_empty : vid_empty;
    assign src_byte  = sel_aud ? aud_in : vid_in;
    assign xfer      = ~rst & clk_en & ~out_full & (state == PAYLOAD) & ~src_empty & (cnt != 16'd0);
    assign vid_rd    = xfer & ~sel_aud;
    assign aud_rd    = xfer & sel_aud;
    assign busy      = (state != IDLE);

    always_comb begin
        hdr_byte = 8'h00;
        case (idx)
            3'd2:    hdr_byte = 8'h01;
            3'd3:    hdr_byte = sel_aud ? AUD_ID : VID_ID;
            3'd4:    hdr_byte = len_q[15:8];
            3'd5:    hdr_byte = len_q[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel_aud  <= 1'b0;
            last_aud <= 1'b1;
            len_q    <= 16'd0;
            cnt      <= 16'd0;
            idx      <= 3'd0;
            mpeg_out <= 8'h00;
            mpeg_wr  <= 1'b0;
            vid_ack  <= 1'b0;
            aud_ack  <= 1'b0;
            vid_gnt  <= 1'b0;
            aud_gnt  <= 1'b0;
        end else if (clk_en) begin
            vid_ack <= 1'b0;
            aud_ack <= 1'b0;
            mpeg_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (vid_req | aud_req) begin
                        sel_aud  <= pick_aud;
                        last_aud <= pick_aud;
                        len_q    <= req_len_clamped;
                        idx      <= 3'd0;
                        vid_ack  <= ~pick_aud;
                        aud_ack  <= pick_aud;
                        vid_gnt  <= ~pick_aud;
                        aud_gnt  <= pick_aud;
                        state    <= HDR;
                    end
                end
                HDR: begin
                    if (~out_full) begin
                        mpeg_out <= hdr_byte;
                        mpeg_wr  <= 1'b1;
                        if (idx == 3'd5) begin
                            idx <= 3'd0;
                            if (len_q == 16'd0) begin
                                state   <= IDLE;
                                vid_gnt <= 1'b0;
                                aud_gnt <= 1'b0;
                            end else begin
                                state <= PAYLOAD;
                                cnt   <= len_q;
                            end
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
                        mpeg_out <= src_byte;
                        mpeg_wr  <= 1'b1;
                        cnt      <= cnt - 16'd1;
                        if (cnt == 16'd1) begin
                            state   <= IDLE;
                            vid_gnt <= 1'b0;
                            aud_gnt <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_arbiter.sv
// Directed bench for stream_arbiter: FIFO models on both inputs, byte capture on the output stream.
module tb_stream_arbiter;

    logic        clk = 1'b0;
    logic        rst, clk_en;
    logic        vid_req, aud_req;
    logic [15:0] vid_len, aud_len;
    logic [7:0]  vid_in, aud_in;
    logic        vid_empty, aud_empty;
    logic        vid_rd, aud_rd, vid_ack, aud_ack, vid_gnt, aud_gnt;
    logic        out_full;
    logic [7:0]  mpeg_out;
    logic        mpeg_wr, busy;

    stream_arbiter dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .vid_req(vid_req), .vid_len(vid_len), .vid_in(vid_in), .vid_empty(vid_empty),
        .vid_rd(vid_rd), .vid_ack(vid_ack), .vid_gnt(vid_gnt),
        .aud_req(aud_req), .aud_len(aud_len), .aud_in(aud_in), .aud_empty(aud_empty),
        .aud_rd(aud_rd), .aud_ack(aud_ack), .aud_gnt(aud_gnt),
        .out_full(out_full), .mpeg_out(mpeg_out), .mpeg_wr(mpeg_wr), .busy(busy)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO models; pointers advance on the edge that sees *_rd.
    logic [7:0]  vmem [0:4095];
    logic [7:0]  amem [0:4095];
    logic [11:0] vwp = '0, vrp = '0, awp = '0, arp = '0;
    logic        vid_hold = 1'b0;

    always @(posedge clk) if (vid_rd) vrp <= vrp + 12'd1;
    always @(posedge clk) if (aud_rd) arp <= arp + 12'd1;

    assign vid_in    = vmem[vrp];
    assign aud_in    = amem[arp];
    assign vid_empty = (vrp == vwp) || vid_hold;
    assign aud_empty = (arp == awp);

    // Downstream view: a byte is taken on each clk_en edge that sees mpeg_wr.
    logic [7:0] cap_b[$];
    int         cap_t[$];
    int         cyc = 0;
    int         vack_n = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (clk_en && mpeg_wr) begin
            cap_b.push_back(mpeg_out);
            cap_t.push_back(cyc);
        end
        if (clk_en && vid_ack) vack_n <= vack_n + 1;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic vpush(input logic [7:0] b);
        vmem[vwp] = b;
        vwp = vwp + 12'd1;
    endtask

    task automatic apush(input logic [7:0] b);
        amem[awp] = b;
        awp = awp + 12'd1;
    endtask

    task automatic wait_ack(input bit aud, input string tag);
        int n = 0;
        while (!(aud ? aud_ack : vid_ack) && n < 20) begin
            step(1);
            n++;
        end
        chk(tag, n < 20, 1);
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int n = 0;
        while (busy && n < bound) begin
            step(1);
            n++;
        end
        chk(tag, busy, 0);
        step(1);
    endtask

    task automatic clear_cap();
        cap_b.delete();
        cap_t.delete();
    endtask

    initial begin
        int          n, nv, v0, base;
        logic [11:0] p0, d;
        logic [7:0]  exp_a [0:8];
        exp_a = '{8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC};

        rst = 1'b1; clk_en = 1'b1; out_full = 1'b0;
        vid_req = 1'b0; aud_req = 1'b0; vid_len = '0; aud_len = '0;
        #2;
        chk("rst_mpeg_out", mpeg_out, 8'h00);
        chk("rst_mpeg_wr", mpeg_wr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gnt", {vid_gnt, aud_gnt, vid_ack, aud_ack}, 0);
        chk("rst_rd", {vid_rd, aud_rd}, 0);
        step(2);
        rst = 1'b0;
        step(1);

        // Single video packet, len 3
        vpush(8'hAA); vpush(8'hBB); vpush(8'hCC);
        clear_cap();
        v0 = vack_n;
        vid_len = 16'd3; vid_req = 1'b1;
        wait_ack(0, "A_ack_timeout");
        chk("A_gnt_after_ack", {vid_gnt, aud_gnt, busy}, 3'b101);
        vid_req = 1'b0;
        wait_idle(40, "A_idle_timeout");
        chk("A_nbytes", cap_b.size(), 9);
        for (int i = 0; i < 9; i++) chk($sformatf("A_byte%0d", i), cap_b[i], exp_a[i]);
        chk("A_contiguous", cap_t[8] - cap_t[0], 8);
        chk("A_ack_pulses", vack_n - v0, 1);
        chk("A_gnt_end", vid_gnt, 0);

        // Tie between both sources after a fresh reset
        rst = 1'b1; step(1); rst = 1'b0; step(1);
        vpush(8'h11); apush(8'h22); vpush(8'h33);
        clear_cap();
        vid_len = 16'd1; aud_len = 16'd1; vid_req = 1'b1; aud_req = 1'b1;
        n = 0; nv = 0;
        while ((vid_req || aud_req || busy) && n < 300) begin
            step(1);
            n++;
            if (vid_ack) begin
                nv++;
                if (nv == 2) vid_req = 1'b0;
            end
            if (aud_ack) aud_req = 1'b0;
        end
        chk("B_timeout", n < 300, 1);
        step(1);
        chk("B_nbytes", cap_b.size(), 21);
        chk("B_id0", cap_b[3], 8'hE0);
        chk("B_pay0", cap_b[6], 8'h11);
        chk("B_id1", cap_b[10], 8'hC0);
        chk("B_pay1", cap_b[13], 8'h22);
        chk("B_id2", cap_b[17], 8'hE0);
        chk("B_pay2", cap_b[20], 8'h33);
        chk("B_gap0", cap_t[7] - cap_t[6], 2);
        chk("B_gap1", cap_t[14] - cap_t[13], 2);

        // Oversized audio length is clamped to MAX_LEN
        for (int j = 0; j < 2048; j++) apush(8'(j * 3 + 1));
        apush(8'h77);
        p0 = arp;
        clear_cap();
        aud_len = 16'hFFFF; aud_req = 1'b1;
        wait_ack(1, "C_ack_timeout");
        aud_req = 1'b0;
        wait_idle(2200, "C_idle_timeout");
        chk("C_nbytes", cap_b.size(), 2054);
        chk("C_len_hi", cap_b[4], 8'h08);
        chk("C_len_lo", cap_b[5], 8'h00);
        chk("C_first_pay", cap_b[6], 8'h01);
        chk("C_last_pay", cap_b[2053], 8'hFE);
        d = arp - p0;
        chk("C_pops", d, 12'd2048);

        // Zero-length packet: header only, FIFO untouched
        vpush(8'h5A);
        p0 = vrp;
        clear_cap();
        vid_len = 16'd0; vid_req = 1'b1;
        wait_ack(0, "D_ack_timeout");
        vid_req = 1'b0;
        wait_idle(40, "D_idle_timeout");
        chk("D_nbytes", cap_b.size(), 6);
        chk("D_id", cap_b[3], 8'hE0);
        chk("D_len_lo", cap_b[5], 8'h00);
        chk("D_no_pop", vrp, p0);

        // out_full toggling every cycle
        vpush(8'h01); vpush(8'h02); vpush(8'h03);
        clear_cap();
        vid_len = 16'd4; vid_req = 1'b1;
        wait_ack(0, "E_ack_timeout");
        vid_req = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            out_full = ~out_full;
            step(1);
            n++;
        end
        out_full = 1'b0;
        chk("E_timeout", n < 100, 1);
        step(1);
        chk("E_nbytes", cap_b.size(), 10);
        base = 6;
        chk("E_pay0", cap_b[base], 8'h5A);
        chk("E_pay1", cap_b[base + 1], 8'h01);
        chk("E_pay2", cap_b[base + 2], 8'h02);
        chk("E_pay3", cap_b[base + 3], 8'h03);
        chk("E_pops", vrp - p0, 12'd4);

        // Empty gap mid-payload, then reset during payload byte 2
        vpush(8'hA1); vpush(8'hA2); vpush(8'hA3); vpush(8'hA4);
        p0 = vrp;
        vid_len = 16'd4; vid_req = 1'b1;
        wait_ack(0, "F_ack_timeout");
        vid_req = 1'b0;
        n = 0;
        while (!vid_rd && n < 20) begin
            step(1);
            n++;
        end
        chk("F_rd_timeout", vid_rd, 1);
        step(1);
        chk("F_byte1", {mpeg_wr, mpeg_out}, {1'b1, 8'hA1});
        vid_hold = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk($sformatf("F_gap_wr%0d", k), mpeg_wr, 0);
            chk($sformatf("F_gap_rd%0d", k), vid_rd, 0);
        end
        vid_hold = 1'b0;
        #1;
        chk("F_rd_resume", vid_rd, 1);
        rst = 1'b1;
        #1;
        chk("F_rst_rd", vid_rd, 0);
        chk("F_rst_outs", {mpeg_wr, busy, vid_gnt}, 3'b000);
        step(2);
        rst = 1'b0;
        step(3);
        chk("F_post_outs", {mpeg_wr, busy, vid_gnt}, 3'b000);
        chk("F_pops", vrp - p0, 12'd1);

        // clk_en low for three cycles mid-header
        clear_cap();
        aud_len = 16'd1; aud_req = 1'b1;
        wait_ack(1, "G_ack_timeout");
        aud_req = 1'b0;
        step(3);
        chk("G_pre_freeze", {mpeg_wr, mpeg_out}, {1'b1, 8'h01});
        clk_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk($sformatf("G_frozen%0d", k), {mpeg_wr, mpeg_out, busy, aud_gnt, aud_rd},
                {1'b1, 8'h01, 1'b1, 1'b1, 1'b0});
        end
        clk_en = 1'b1;
        wait_idle(40, "G_idle_timeout");
        chk("G_nbytes", cap_b.size(), 7);
        chk("G_id", cap_b[3], 8'hC0);
        chk("G_len_lo", cap_b[5], 8'h01);
        chk("G_pay", cap_b[6], 8'h77);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
